// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console screen buffer.
package text_console_pkg;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;
  localparam int ADDR_W   = $clog2(DEF_COLS * DEF_ROWS);

  localparam logic [7:0] BLANK_CODE = 8'h20;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_FF      = 8'h0C;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_e;
endpackage

// File: rtl/text_console_if.sv
// Byte-stream write channel plus pixel lookup and cursor status.
interface text_console_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] character;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;

  modport master (output wr_valid, wr_data, pos_x, pos_y,
                  input  wr_ready, character, cursor_x, cursor_y);
  modport slave  (input  wr_valid, wr_data, pos_x, pos_y,
                  output wr_ready, character, cursor_x, cursor_y);
endinterface

// File: rtl/char_ram.sv
// Simple dual-port character RAM: one sync write port, one registered read port.
module char_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; a same-cycle write to the same cell is seen on the next read.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/text_console.sv
// Text-mode screen buffer: cursor writer with wrap/scroll plus 1-cycle pixel lookup.
module text_console
  import text_console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = BLANK_CODE
) (
  input  logic           px_clk,
  input  logic           reset,
  text_console_if.slave  bus
);
  localparam int            N        = COLS * ROWS;
  localparam int            AW       = $clog2(N);
  localparam logic [6:0]    COLS_W   = 7'(COLS);
  localparam logic [6:0]    ROWS_W   = 7'(ROWS);
  localparam logic [6:0]    COL_MAX  = 7'(COLS - 1);
  localparam logic [5:0]    ROW_MAX  = 6'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ALL = AW'(N - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(COLS - 1);

  // Logical row -> physical address; scroll is just the top_row offset.
  function automatic logic [AW-1:0] map_addr(input logic [6:0] row, input logic [6:0] col,
                                             input logic [5:0] top);
    logic [6:0] r;
    r = row + {1'b0, top};
    if (r >= ROWS_W) r = r - ROWS_W;
    return AW'(r) * AW'(COLS) + AW'(col);
  endfunction

  state_e        state_q, state_d;
  logic [6:0]    cx_q, cx_d;
  logic [5:0]    cy_q, cy_d;
  logic [5:0]    top_q, top_d;
  logic [5:0]    clr_row_q, clr_row_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          oor_q, oor_d;

  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    wdata, rdata;
  logic          accept, is_print, newline;
  logic [6:0]    lk_col, lk_row;
  logic          lookup_unused;

  assign accept   = bus.wr_valid && (state_q == IDLE);
  assign is_print = !(bus.wr_data inside {CH_CR, CH_LF, CH_BS, CH_FF});
  assign newline  = accept && ((bus.wr_data == CH_LF) || (is_print && cx_q == COL_MAX));
  assign lk_col   = bus.pos_x[9:3];
  assign lk_row   = bus.pos_y[9:3];
  assign lookup_unused = ^{bus.pos_x[2:0], bus.pos_y[2:0]};

  // State and datapath registers; reset restarts the full clear.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLR_ALL;
      cx_q      <= '0;
      cy_q      <= '0;
      top_q     <= '0;
      clr_row_q <= '0;
      clr_cnt_q <= '0;
      oor_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      top_q     <= top_d;
      clr_row_q <= clr_row_d;
      clr_cnt_q <= clr_cnt_d;
      oor_q     <= oor_d;
    end
  end

  // Next state: clears run to their last cell, FF and bottom-row newline start clears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_ALL: if (clr_cnt_q == LAST_ALL) state_d = IDLE;
      CLR_ROW: if (clr_cnt_q == LAST_ROW) state_d = IDLE;
      IDLE: begin
        if (accept && bus.wr_data == CH_FF)     state_d = CLR_ALL;
        else if (newline && cy_q == ROW_MAX)    state_d = CLR_ROW;
      end
      default: state_d = CLR_ALL;
    endcase
  end

  // Outputs: RAM write port, cursor/top_row updates and the lookup address.
  always_comb begin
    cx_d      = cx_q;
    cy_d      = cy_q;
    top_d     = top_q;
    clr_row_d = clr_row_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = BLANK;
    case (state_q)
      CLR_ALL: begin
        we        = 1'b1;
        waddr     = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
      CLR_ROW: begin
        we        = 1'b1;
        waddr     = AW'(clr_row_q) * AW'(COLS) + clr_cnt_q;
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
      IDLE: begin
        clr_cnt_d = '0;
        if (accept) begin
          case (bus.wr_data)
            CH_CR: cx_d = '0;
            CH_LF: ;
            CH_BS: begin
              if (cx_q != '0) begin
                cx_d  = cx_q - 7'd1;
                we    = 1'b1;
                waddr = map_addr({1'b0, cy_q}, cx_q - 7'd1, top_q);
              end
            end
            CH_FF: begin
              cx_d  = '0;
              cy_d  = '0;
              top_d = '0;
            end
            default: begin
              we    = 1'b1;
              waddr = map_addr({1'b0, cy_q}, cx_q, top_q);
              wdata = bus.wr_data;
              cx_d  = (cx_q == COL_MAX) ? 7'd0 : cx_q + 7'd1;
            end
          endcase
          if (newline) begin
            if (cy_q < ROW_MAX) begin
              cy_d = cy_q + 6'd1;
            end else begin
              clr_row_d = top_q;
              top_d     = (top_q == ROW_MAX) ? 6'd0 : top_q + 6'd1;
            end
          end
        end
      end
      default: ;
    endcase
    oor_d = (lk_col >= COLS_W) || (lk_row >= ROWS_W);
    raddr = oor_d ? '0 : map_addr(lk_row, lk_col, top_q);
  end

  char_ram #(.DEPTH(N), .AW(AW)) u_ram (
    .clk   (px_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.wr_ready  = (state_q == IDLE);
  assign bus.character = oor_q ? BLANK : rdata;
  assign bus.cursor_x  = cx_q;
  assign bus.cursor_y  = cy_q;
endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor pops and compares.
module tb_text_console;
  import text_console_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_console_if bus();
  text_console dut (.px_clk(clk), .reset(reset), .bus(bus));

  typedef struct { string name; logic [7:0] ch; } char_exp_t;
  typedef struct { string name; int cx; int cy; int rdy; logic use_ch; logic [7:0] ch; } st_exp_t;

  char_exp_t char_q[$];
  st_exp_t   st_q[$];
  int        rdy_q[$];
  int        n_pass = 0;
  int        n_tot  = 0;
  logic      lk_req = 1'b0, lk_d = 1'b0, st_req = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Lookup results appear one cycle after the request.
  always @(posedge clk) lk_d <= lk_req;

  char_exp_t ce;
  st_exp_t   se;
  int        re;
  int        lowcnt = 0;
  logic      rdy_prev = 1'b0;

  // Monitor: compares lookups, status samples and wr_ready low-time.
  always @(negedge clk) begin
    if (lk_d) begin
      if (char_q.size() == 0) begin n_tot++; $display("FAIL char_unexpected: no expectation"); end
      else begin ce = char_q.pop_front(); chk(ce.name, int'(bus.character), int'(ce.ch)); end
    end
    if (st_req) begin
      if (st_q.size() == 0) begin n_tot++; $display("FAIL state_unexpected: no expectation"); end
      else begin
        se = st_q.pop_front();
        chk({se.name, "_cx"}, int'(bus.cursor_x), se.cx);
        chk({se.name, "_cy"}, int'(bus.cursor_y), se.cy);
        chk({se.name, "_rdy"}, int'(bus.wr_ready), se.rdy);
        if (se.use_ch) chk({se.name, "_char"}, int'(bus.character), int'(se.ch));
      end
    end
    if (reset) lowcnt = 0;
    else if (!bus.wr_ready) lowcnt++;
    else if (!rdy_prev) begin
      if (rdy_q.size() == 0) begin n_tot++; $display("FAIL ready_rise: unexpected after %0d", lowcnt); end
      else begin re = rdy_q.pop_front(); chk("ready_low_cycles", lowcnt, re); end
      lowcnt = 0;
    end
    rdy_prev = bus.wr_ready;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look(int x, int y, logic [7:0] e);
    char_q.push_back('{name: $sformatf("char(%0d,%0d)", x, y), ch: e});
    bus.pos_x = 10'(x);
    bus.pos_y = 10'(y);
    lk_req = 1'b1;
    tick();
    lk_req = 1'b0;
  endtask

  task automatic status(string nm, int cx, int cy, int rdy, logic use_ch, logic [7:0] ch);
    st_q.push_back('{name: nm, cx: cx, cy: cy, rdy: rdy, use_ch: use_ch, ch: ch});
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask

  task automatic send(logic [7:0] b);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    while (!bus.wr_ready && n < 6000) begin tick(); n++; end
    if (n >= 6000) begin n_tot++; $display("FAIL send_timeout: byte 0x%0h not accepted", b); end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.wr_ready && n < 6000) begin tick(); n++; end
    if (n >= 6000) begin n_tot++; $display("FAIL ready_timeout: wr_ready stuck low"); end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.pos_x    = '0;
    bus.pos_y    = '0;
    repeat (3) tick();
    status("reset", 0, 0, 0, 1'b1, 8'h20);
    rdy_q.push_back(4800);
    reset = 1'b0;
    wait_ready();
    status("cleared", 0, 0, 1, 1'b0, 8'h00);
    look(0, 0, 8'h20); look(639, 479, 8'h20); look(320, 240, 8'h20);
    look(1000, 0, 8'h20); look(0, 500, 8'h20);

    send(8'h41); send(8'h42);
    look(0, 0, 8'h41); look(8, 0, 8'h42); look(7, 7, 8'h41); look(16, 0, 8'h20);
    status("ab", 2, 0, 1, 1'b0, 8'h00);

    send(CH_CR);
    status("cr", 0, 0, 1, 1'b0, 8'h00);
    repeat (80) send(8'h78);
    status("wrap", 0, 1, 1, 1'b0, 8'h00);
    look(632, 0, 8'h78); look(640, 0, 8'h20); look(0, 0, 8'h78); look(0, 8, 8'h20);

    send(8'h51);
    look(0, 8, 8'h51);
    status("q", 1, 1, 1, 1'b0, 8'h00);
    send(CH_BS);
    look(0, 8, 8'h20);
    status("bs", 0, 1, 1, 1'b0, 8'h00);
    send(CH_BS);
    status("bs_col0", 0, 1, 1, 1'b0, 8'h00);

    // Mark old row 1 and row 59, then scroll once.
    send(8'h52); send(CH_CR);
    repeat (58) send(CH_LF);
    send(8'h5A); send(CH_CR);
    status("row59", 0, 59, 1, 1'b0, 8'h00);
    rdy_q.push_back(80);
    send(CH_LF);
    wait_ready();
    status("scroll", 0, 59, 1, 1'b0, 8'h00);
    look(0, 0, 8'h52); look(8, 0, 8'h20); look(0, 464, 8'h5A);
    look(0, 472, 8'h20); look(632, 472, 8'h20);
    send(8'h57);
    look(0, 472, 8'h57); look(8, 472, 8'h20);
    status("after_w", 1, 59, 1, 1'b0, 8'h00);

    rdy_q.push_back(4800);
    send(CH_FF);
    wait_ready();
    status("ff", 0, 0, 1, 1'b0, 8'h00);
    look(0, 0, 8'h20); look(0, 464, 8'h20); look(0, 472, 8'h20);
    send(8'h4B);
    look(0, 0, 8'h4B);
    status("k", 1, 0, 1, 1'b0, 8'h00);

    // Reset in the middle of a row clear with a byte held on the bus.
    send(CH_CR);
    repeat (59) send(CH_LF);
    send(CH_LF);
    repeat (10) tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h4D;
    tick();
    reset = 1'b1;
    tick();
    status("rst_mid", 0, 0, 0, 1'b1, 8'h20);
    rdy_q.push_back(4800);
    reset = 1'b0;
    wait_ready();
    bus.wr_valid = 1'b0;
    status("no_consume", 0, 0, 1, 1'b0, 8'h00);
    look(0, 0, 8'h20);
    repeat (3) tick();

    if (char_q.size() != 0 || st_q.size() != 0 || rdy_q.size() != 0) begin
      n_tot++;
      $display("FAIL leftover: %0d/%0d/%0d expectations never checked",
               char_q.size(), st_q.size(), rdy_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
